// File: rtl/ysyx_23060061_arbiter.sv
// ysyx_23060061_arbiter
//   Two-master AXI-lite arbiter. The IFU (read only) and the LSU (read and
//   write) share one downstream AXI-lite master port toward the crossbar.
//   At most one transaction is outstanding at a time. Every transaction
//   returns through IDLE for one cycle before the next grant.
//
// Parameters
//   RR : 1 = round-robin between IFU and LSU on a tie, 0 = LSU always wins.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   ifu_ar* / ifu_r*             : IFU read address and read data channels
//   lsu_ar* / lsu_r*             : LSU read address and read data channels
//   lsu_aw* / lsu_w* / lsu_b*    : LSU write address, data and response
//   ar* r* aw* w* b*             : downstream AXI-lite master port
module ysyx_23060061_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        rst,
  // IFU
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  // LSU
  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // downstream
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state_q, state_d;
  // last granted master: 1 = LSU, 0 = IFU
  logic   last_lsu_q, last_lsu_d;

  logic ifu_req, lsu_wr_req, lsu_req, lsu_wins_tie;

  assign ifu_req      = ifu_arvalid;
  // a write is only taken once address and data are both offered
  assign lsu_wr_req   = lsu_awvalid && lsu_wvalid;
  assign lsu_req      = lsu_wr_req || lsu_arvalid;
  assign lsu_wins_tie = (RR == 0) ? 1'b1 : !last_lsu_q;

  always_comb begin
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    case (state_q)
      IDLE: begin
        if (lsu_req && (!ifu_req || lsu_wins_tie))
          state_d = lsu_wr_req ? LSU_WR : LSU_RD;
        else if (ifu_req)
          state_d = IFU_RD;
      end
      IFU_RD, LSU_RD: if (rvalid && rready) state_d = IDLE;
      LSU_WR:         if (bvalid && bready) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
    if (state_q == IDLE && state_d != IDLE)
      last_lsu_d = (state_d != IFU_RD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  // Pure routing: everything not belonging to the granted path stays 0,
  // which also keeps all handshakes closed while IDLE.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    araddr      = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awaddr      = '0;
    awvalid     = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    case (state_q)
      IFU_RD: begin
        araddr      = ifu_araddr;
        arvalid     = ifu_arvalid;
        ifu_arready = arready;
        ifu_rdata   = rdata;
        ifu_rresp   = rresp;
        ifu_rvalid  = rvalid;
        rready      = ifu_rready;
      end
      LSU_RD: begin
        araddr      = lsu_araddr;
        arvalid     = lsu_arvalid;
        lsu_arready = arready;
        lsu_rdata   = rdata;
        lsu_rresp   = rresp;
        lsu_rvalid  = rvalid;
        rready      = lsu_rready;
      end
      LSU_WR: begin
        awaddr      = lsu_awaddr;
        awvalid     = lsu_awvalid;
        lsu_awready = awready;
        wdata       = lsu_wdata;
        wstrb       = lsu_wstrb;
        wvalid      = lsu_wvalid;
        lsu_wready  = wready;
        lsu_bresp   = bresp;
        lsu_bvalid  = bvalid;
        bready      = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule
